// File: rtl/timer_ctrl_pkg.sv
// Shared types and defaults for the countdown timer controller.
// One-hot state encoding; BCD digit limits.
package timer_ctrl_pkg;

  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    RUN     = 7'b0000010,
    PAUSE   = 7'b0000100,
    FINISH  = 7'b0001000,
    ALARM_S = 7'b0010000,
    ABORT   = 7'b0100000,
    DRAIN   = 7'b1000000
  } state_t;

  localparam logic [3:0]  DIGIT_MAX      = 4'd9;
  localparam logic [3:0]  TENS_MAX_DEF   = 4'd5;
  localparam int unsigned ABORT_HOLD_DEF = 2;

endpackage

// File: rtl/timer_ctrl_bcd_down_digit.sv
// One BCD down-counting digit with load priority and wrap-to-max borrow.
// Registered q, one-cycle update; no backpressure (dec is a single-cycle strobe).
module bcd_down_digit
  import timer_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic [3:0] max_val,
  output logic [3:0] q,
  output logic       zero,
  output logic       borrow_out
);

  assign zero       = (q == 4'd0);
  assign borrow_out = dec && zero;

  always_ff @(posedge CLK) begin
    if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= zero ? max_val : q - 4'd1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/clear controller for the 1 Hz seconds-ones counter; owns the tens and minutes digits.
// Outputs registered (one cycle after the deciding edge) except VAL_SET; button pulses are never stalled.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned ALARM_CYCLES = 300_000_000,
  parameter int unsigned ABORT_HOLD   = ABORT_HOLD_DEF,
  parameter logic [3:0]  TENS_MAX     = TENS_MAX_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_SS,
  input  logic       BTN_CLR,
  input  logic [3:0] PRE_SEC_O,
  input  logic [3:0] PRE_SEC_T,
  input  logic [3:0] PRE_MIN,
  input  logic [3:0] VAL,
  input  logic       EN_SEC,
  input  logic       BUSY,
  output logic       EN,
  output logic       DONE,
  output logic [3:0] VAL_SET,
  output logic [3:0] SEC_T,
  output logic [3:0] MIN_O,
  output logic       ALARM,
  output logic       RUNNING
);

  state_t      state, state_n;
  logic [31:0] dwell;
  logic        sec_zero, min_zero, sec_borrow, min_borrow;
  logic        at_zero, borrow_req, digit_load;

  assign VAL_SET    = PRE_SEC_O;
  assign at_zero    = (VAL == 4'd0) && sec_zero && min_zero;
  assign borrow_req = (state == RUN) && EN_SEC && (VAL == 4'd0) && !at_zero;
  assign digit_load = RST || (state == IDLE) || ((state == DRAIN) && !BUSY);

  bcd_down_digit u_sec_t (
    .CLK        (CLK),
    .load       (digit_load),
    .load_val   (PRE_SEC_T),
    .dec        (borrow_req),
    .max_val    (TENS_MAX),
    .q          (SEC_T),
    .zero       (sec_zero),
    .borrow_out (sec_borrow)
  );

  bcd_down_digit u_min (
    .CLK        (CLK),
    .load       (digit_load),
    .load_val   (PRE_MIN),
    .dec        (sec_borrow),
    .max_val    (DIGIT_MAX),
    .q          (MIN_O),
    .zero       (min_zero),
    .borrow_out (min_borrow)
  );

  // A minutes underflow can only come from out-of-range presets; treat it as expiry.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (BTN_SS) state_n = RUN;
      RUN: begin
        if (at_zero || min_borrow) state_n = FINISH;
        else if (BTN_CLR)          state_n = ABORT;
        else if (BTN_SS)           state_n = PAUSE;
      end
      PAUSE: begin
        if (BTN_CLR)     state_n = ABORT;
        else if (BTN_SS) state_n = RUN;
      end
      FINISH:  state_n = ALARM_S;
      ALARM_S: if (BTN_SS || BTN_CLR || (dwell == ALARM_CYCLES - 1)) state_n = DRAIN;
      ABORT:   if (dwell == ABORT_HOLD - 1) state_n = DRAIN;
      DRAIN:   if (!BUSY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // dwell restarts on every state change, timing both the alarm and the abort hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dwell   <= '0;
      EN      <= 1'b0;
      DONE    <= 1'b0;
      ALARM   <= 1'b0;
      RUNNING <= 1'b0;
    end else begin
      state   <= state_n;
      dwell   <= (state_n != state) ? 32'd0 : dwell + 32'd1;
      EN      <= (state_n == RUN) || (state_n == FINISH) || (state_n == ABORT);
      DONE    <= (state_n == FINISH) || (state_n == ABORT);
      ALARM   <= (state_n == ALARM_S);
      RUNNING <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with a behavioural seconds-ones counter (CNT_FULL=10) on the EN/DONE/BUSY side.
module tb_timer_ctrl;

  localparam int CNT_FULL  = 10;
  localparam int ALARM_CYC = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_SS = 1'b0, BTN_CLR = 1'b0;
  logic [3:0] PRE_SEC_O = 4'd2, PRE_SEC_T = 4'd1, PRE_MIN = 4'd0;
  logic [3:0] VAL, VAL_SET, SEC_T, MIN_O;
  logic       EN_SEC, BUSY, EN, DONE, ALARM, RUNNING;
  logic [3:0] presc;

  always #5 CLK = ~CLK;

  timer_ctrl #(.ALARM_CYCLES(ALARM_CYC), .ABORT_HOLD(2), .TENS_MAX(4'd5)) dut (
    .CLK(CLK), .RST(RST), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR),
    .PRE_SEC_O(PRE_SEC_O), .PRE_SEC_T(PRE_SEC_T), .PRE_MIN(PRE_MIN),
    .VAL(VAL), .EN_SEC(EN_SEC), .BUSY(BUSY),
    .EN(EN), .DONE(DONE), .VAL_SET(VAL_SET), .SEC_T(SEC_T), .MIN_O(MIN_O),
    .ALARM(ALARM), .RUNNING(RUNNING)
  );

  // Counter model: idle tracks VAL_SET, starts on EN without DONE, any DONE returns it to idle.
  assign EN_SEC = BUSY && EN && (presc == 4'(CNT_FULL - 1));
  always @(posedge CLK) begin
    if (RST) begin
      BUSY <= 1'b0; presc <= 4'd0; VAL <= VAL_SET;
    end else if (!BUSY) begin
      VAL <= VAL_SET; presc <= 4'd0;
      if (EN && !DONE) BUSY <= 1'b1;
    end else if (DONE) begin
      BUSY <= 1'b0;
    end else if (EN) begin
      presc <= (presc == 4'(CNT_FULL - 1)) ? 4'd0 : presc + 4'd1;
      if (presc == 4'(CNT_FULL - 1)) VAL <= (VAL == 4'd0) ? 4'd9 : VAL - 4'd1;
    end
  end

  typedef struct { logic [3:0] val; logic [3:0] sec_t; logic [3:0] min_o; } exp_t;
  typedef struct { int pm; int pt; int po; int pause_at; int cut; } vec_t;

  exp_t sb[$];
  int   n_err = 0, n_checks = 0, ticks_seen = 0, done_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected display after each of the next n ticks, from plain seconds arithmetic.
  task automatic push_expected(input int t0, input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.min_o = 4'((t0 - k) / 60);
      e.sec_t = 4'(((t0 - k) % 60) / 10);
      e.val   = 4'((t0 - k) % 10);
      sb.push_back(e);
    end
  endtask

  task automatic step_mon();
    logic tick;
    exp_t e;
    tick = EN_SEC;
    @(posedge CLK); #1;
    if (DONE === 1'b1) done_cycles++;
    if (tick) begin
      ticks_seen++;
      if (sb.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL spurious_tick: got tick %0d, expected none", ticks_seen);
      end else begin
        e = sb.pop_front();
        check("tick_val",   {28'd0, VAL},   {28'd0, e.val});
        check("tick_sec_t", {28'd0, SEC_T}, {28'd0, e.sec_t});
        check("tick_min",   {28'd0, MIN_O}, {28'd0, e.min_o});
      end
    end
  endtask

  task automatic set_preset(input int pm, input int pt, input int po);
    PRE_MIN = 4'(pm); PRE_SEC_T = 4'(pt); PRE_SEC_O = 4'(po);
    repeat (3) step_mon();
  endtask

  task automatic press_ss();
    BTN_SS = 1'b1; step_mon(); BTN_SS = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int t0, lat, guard, alarm_len;
    logic [3:0] frozen;
    logic hold_ok, paused;
    t0 = v.pm * 60 + v.pt * 10 + v.po;
    set_preset(v.pm, v.pt, v.po);
    check("idle_sec_t",   SEC_T,   v.pt);
    check("idle_min",     MIN_O,   v.pm);
    check("idle_val_set", VAL_SET, v.po);
    check("idle_val",     VAL,     v.po);
    sb.delete(); ticks_seen = 0; done_cycles = 0;
    push_expected(t0, t0);
    press_ss(); lat = 1;
    check("start_en", EN, 1);
    check("start_running", RUNNING, 1);
    paused = 1'b0; guard = 0;
    while (DONE !== 1'b1 && guard < t0 * CNT_FULL + 200) begin
      if (v.pause_at >= 0 && !paused && ticks_seen == v.pause_at) begin
        paused = 1'b1;
        press_ss(); step_mon();
        frozen = VAL; hold_ok = 1'b1;
        repeat (50) begin
          step_mon();
          if (EN !== 1'b0 || VAL !== frozen) hold_ok = 1'b0;
        end
        check("pause_en", EN, 0);
        check("pause_val", frozen, (t0 - v.pause_at) % 10);
        check("pause_hold", hold_ok, 1);
        press_ss();
      end else begin
        step_mon(); lat++;
      end
      guard++;
    end
    check("done_seen", DONE, 1);
    check("done_val", VAL, 0);
    check("done_sec_t", SEC_T, 0);
    check("done_min", MIN_O, 0);
    check("done_en", EN, 1);
    if (t0 == 0) check("zero_latency_le2", (lat <= 2) ? 1 : 0, 1);
    step_mon();
    check("done_cycles", done_cycles, 1);
    check("alarm_en", EN, 0);
    alarm_len = 0; guard = 0;
    while (ALARM === 1'b1 && guard < 100) begin
      alarm_len++;
      if (v.cut != 0 && alarm_len == v.cut) BTN_SS = 1'b1;
      step_mon(); BTN_SS = 1'b0; guard++;
    end
    check("alarm_len", alarm_len, (v.cut != 0) ? v.cut : ALARM_CYC);
    check("tick_count", ticks_seen, t0);
    check("sb_empty", sb.size(), 0);
    repeat (2) step_mon();
    check("end_busy", BUSY, 0);
    check("end_running", RUNNING, 0);
    check("end_sec_t", SEC_T, v.pt);
    check("end_min", MIN_O, v.pm);
  endtask

  task automatic abort_seq();
    int guard, both;
    set_preset(0, 3, 7);
    sb.delete(); ticks_seen = 0;
    push_expected(37, 37);
    press_ss();
    guard = 0;
    while (ticks_seen < 3 && guard < 100) begin step_mon(); guard++; end
    check("abort_ticks", ticks_seen, 3);
    press_ss();
    PRE_MIN = 4'd7;
    repeat (3) step_mon();
    check("pause_preset_ignored", MIN_O, 0);
    check("pause_sec_t", SEC_T, 3);
    check("pause_en_low", EN, 0);
    PRE_MIN = 4'd0;
    BTN_CLR = 1'b1; step_mon(); BTN_CLR = 1'b0;
    both = 0; guard = 0;
    while (EN === 1'b1 && DONE === 1'b1 && guard < 10) begin both++; step_mon(); guard++; end
    check("abort_hold", both, 2);
    check("abort_en_off", EN, 0);
    check("abort_done_off", DONE, 0);
    guard = 0;
    while (BUSY !== 1'b0 && guard < 20) begin step_mon(); guard++; end
    check("abort_busy", BUSY, 0);
    repeat (2) step_mon();
    check("abort_val", VAL, 7);
    check("abort_sec_t", SEC_T, 3);
    check("abort_running", RUNNING, 0);
    check("abort_ticks_after", ticks_seen, 3);
    sb.delete();
  endtask

  task automatic reset_seq();
    int guard;
    set_preset(0, 2, 4);
    sb.delete(); ticks_seen = 0;
    push_expected(24, 24);
    press_ss();
    guard = 0;
    while (ticks_seen < 5 && guard < 200) begin step_mon(); guard++; end
    check("rst_pre_sec_t", SEC_T, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_en", EN, 0);
    check("rst_alarm", ALARM, 0);
    check("rst_running", RUNNING, 0);
    check("rst_sec_t", SEC_T, 2);
    check("rst_min", MIN_O, 0);
    RST = 1'b0;
    sb.delete();
    step_mon();
  endtask

  initial begin
    vec_t vt[5];
    vt[0] = '{0, 1, 2, -1, 0};
    vt[1] = '{1, 0, 0, -1, 0};
    vt[2] = '{0, 0, 5,  2, 0};
    vt[3] = '{0, 0, 0, -1, 5};
    vt[4] = '{2, 0, 3, -1, 0};

    repeat (3) @(posedge CLK);
    #1;
    check("reset_en", EN, 0);
    check("reset_done", DONE, 0);
    check("reset_alarm", ALARM, 0);
    check("reset_running", RUNNING, 0);
    check("reset_sec_t", SEC_T, 1);
    check("reset_min", MIN_O, 0);
    RST = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);
    abort_seq();
    reset_seq();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
